// File: rtl/controlador_pkg.sv
// ---------------------------------------------------------------------------
// controlador_pkg
// Shared types and default constants for the gate controller.
//   estado_t      : FSM state encoding (2 bits)
//   DEF_*         : default parameter values for controlador_gen2
//   TMR_W         : width of the open-gate timer
// ---------------------------------------------------------------------------
package controlador_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ESPERA_PIN = 2'd1,
    ABIERTO    = 2'd2,
    BLOQUEO    = 2'd3
  } estado_t;

  localparam int         DEF_PIN_W     = 8;
  localparam logic [7:0] DEF_CLAVE     = 8'h2A;
  localparam int         DEF_MAX_TRIES = 3;
  localparam int         DEF_T_OPEN    = 16;
  localparam int         TMR_W         = 16;

endpackage

// File: rtl/controlador_gen2_temporizador.sv
// ---------------------------------------------------------------------------
// temporizador
// 16-bit up-counter timing how long the gate has been open.
// Ports:
//   Clk, Reset : clock / asynchronous active-low reset
//   i_clr      : synchronous clear to 0 (wins over i_en)
//   i_en       : count enable
//   o_tc       : terminal count, high while the count equals T_OPEN-1
// ---------------------------------------------------------------------------
module temporizador
  import controlador_pkg::*;
#(
  parameter int T_OPEN = DEF_T_OPEN
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [TMR_W-1:0] LP_TC  = TMR_W'(T_OPEN - 1);
  localparam logic [TMR_W-1:0] LP_UNO = TMR_W'(1);

  logic [TMR_W-1:0] r_cuenta;
  logic             w_tc;

  assign w_tc = (r_cuenta == LP_TC);
  assign o_tc = w_tc;

  // Holds at terminal count so the flag stays asserted if the owner lingers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cuenta <= '0;
    end else if (i_clr) begin
      r_cuenta <= '0;
    end else if (i_en && !w_tc) begin
      r_cuenta <= r_cuenta + LP_UNO;
    end
  end

endmodule

// File: rtl/controlador_gen2.sv
// ---------------------------------------------------------------------------
// controlador_gen2
// PIN-operated vehicle gate controller (registered Moore FSM).
// Ports:
//   Clk        : clock, rising edge
//   Reset      : asynchronous active-low reset
//   Vehiculo   : vehicle present at entry sensor
//   Pin_valido : one-cycle strobe qualifying Pin
//   Pin        : PIN value [PIN_W-1:0]
//   Termino    : vehicle crossed exit sensor
//   Cerrado    : gate closed
//   Abierto    : gate open
//   Alarma     : alarm (wrong-PIN limit reached or lockout)
//   Bloqueo    : lockout after tailgating
//   Intentos   : consecutive wrong-PIN count [3:0]
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | gate closed, waiting for a vehicle
// ESPERA_PIN | vehicle present, waiting for a PIN entry
// ABIERTO    | gate open, waiting for exit sensor or timeout
// BLOQUEO    | tailgating detected, only the correct PIN releases it
// ---------------------------------------------------------------------------
module controlador_gen2
  import controlador_pkg::*;
#(
  parameter int               PIN_W     = DEF_PIN_W,
  parameter logic [PIN_W-1:0] CLAVE     = PIN_W'(DEF_CLAVE),
  parameter int               MAX_TRIES = DEF_MAX_TRIES,
  parameter int               T_OPEN    = DEF_T_OPEN
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Vehiculo,
  input  logic             Pin_valido,
  input  logic [PIN_W-1:0] Pin,
  input  logic             Termino,
  output logic             Cerrado,
  output logic             Abierto,
  output logic             Alarma,
  output logic             Bloqueo,
  output logic [3:0]       Intentos
);

  localparam logic [3:0] LP_MAX = 4'(MAX_TRIES);

  estado_t    r_estado;
  estado_t    w_estado_sig;
  logic [3:0] r_intentos;
  logic [3:0] w_intentos_sig;
  logic       r_cerrado;
  logic       r_abierto;
  logic       r_alarma;
  logic       r_bloqueo;
  logic       w_pin_ok;
  logic       w_pin_mal;
  logic       w_tc;
  logic       w_tmr_clr;
  logic       w_tmr_en;

  assign w_pin_ok  = Pin_valido && (Pin == CLAVE);
  assign w_pin_mal = Pin_valido && (Pin != CLAVE);

  // Timer sits at 0 outside ABIERTO, so it starts from 0 on every entry.
  assign w_tmr_clr = (r_estado != ABIERTO);
  assign w_tmr_en  = (r_estado == ABIERTO);

  temporizador #(
    .T_OPEN (T_OPEN)
  ) u_temporizador (
    .Clk   (Clk),
    .Reset (Reset),
    .i_clr (w_tmr_clr),
    .i_en  (w_tmr_en),
    .o_tc  (w_tc)
  );

  always_comb begin
    w_estado_sig   = r_estado;
    w_intentos_sig = r_intentos;
    case (r_estado)
      IDLE: begin
        if (Vehiculo) w_estado_sig = ESPERA_PIN;
      end
      ESPERA_PIN: begin
        // A PIN strobe is judged before a simultaneous vehicle drop.
        if (w_pin_ok) begin
          w_estado_sig   = ABIERTO;
          w_intentos_sig = '0;
        end else if (w_pin_mal) begin
          if (r_intentos < LP_MAX) w_intentos_sig = r_intentos + 4'd1;
          if (!Vehiculo) w_estado_sig = IDLE;
        end else if (!Vehiculo) begin
          w_estado_sig = IDLE;
        end
      end
      ABIERTO: begin
        if (Termino) begin
          w_estado_sig = Vehiculo ? BLOQUEO : IDLE;
        end else if (w_tc) begin
          w_estado_sig = IDLE;
        end
      end
      BLOQUEO: begin
        if (w_pin_ok) begin
          w_estado_sig   = IDLE;
          w_intentos_sig = '0;
        end
      end
      default: begin
        w_estado_sig = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_estado <= IDLE;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  // Outputs are registered from the next-state values so they change on the
  // same edge as the state and are glitch-free.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_intentos <= '0;
      r_cerrado  <= 1'b1;
      r_abierto  <= 1'b0;
      r_alarma   <= 1'b0;
      r_bloqueo  <= 1'b0;
    end else begin
      r_intentos <= w_intentos_sig;
      r_cerrado  <= (w_estado_sig != ABIERTO);
      r_abierto  <= (w_estado_sig == ABIERTO);
      r_bloqueo  <= (w_estado_sig == BLOQUEO);
      r_alarma   <= (w_estado_sig == BLOQUEO) || (w_intentos_sig == LP_MAX);
    end
  end

  assign Intentos = r_intentos;
  assign Cerrado  = r_cerrado;
  assign Abierto  = r_abierto;
  assign Alarma   = r_alarma;
  assign Bloqueo  = r_bloqueo;

endmodule

// File: tb/tb_controlador_gen2.sv
module tb_controlador_gen2;

  logic        Clk;
  logic        Reset;

  // default instance
  logic        veh, pv, term;
  logic [7:0]  pin;
  logic        cer, abi, ala, blo;
  logic [3:0]  inten;
  logic [7:0]  sa;

  // PIN_W=12, MAX_TRIES=5, T_OPEN=4 instance
  logic        b_veh, b_pv, b_term;
  logic [11:0] b_pin;
  logic        b_cer, b_abi, b_ala, b_blo;
  logic [3:0]  b_inten;
  logic [7:0]  sb;

  int n_checks;
  int n_fail;
  int n;

  assign sa = {blo, ala, abi, cer, inten};
  assign sb = {b_blo, b_ala, b_abi, b_cer, b_inten};

  controlador_gen2 u_dut_a (
    .Clk(Clk), .Reset(Reset), .Vehiculo(veh), .Pin_valido(pv), .Pin(pin),
    .Termino(term), .Cerrado(cer), .Abierto(abi), .Alarma(ala),
    .Bloqueo(blo), .Intentos(inten)
  );

  controlador_gen2 #(
    .PIN_W(12), .CLAVE(12'hA5C), .MAX_TRIES(5), .T_OPEN(4)
  ) u_dut_b (
    .Clk(Clk), .Reset(Reset), .Vehiculo(b_veh), .Pin_valido(b_pv), .Pin(b_pin),
    .Termino(b_term), .Cerrado(b_cer), .Abierto(b_abi), .Alarma(b_ala),
    .Bloqueo(b_blo), .Intentos(b_inten)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chequear(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic paso();
    @(posedge Clk);
    #1;
  endtask

  // {Bloqueo, Alarma, Abierto, Cerrado, Intentos}
  function automatic logic [7:0] st(input logic b, input logic al, input logic ab,
                                    input logic ce, input logic [3:0] i);
    return {b, al, ab, ce, i};
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    veh = 0; pv = 0; term = 0; pin = '0;
    b_veh = 0; b_pv = 0; b_term = 0; b_pin = '0;
    Reset = 1'b1;
    #1 Reset = 1'b0;
    #2;
    chequear("reset_a", 32'(sa), 32'(st(0, 0, 0, 1, 0)));
    chequear("reset_b", 32'(sb), 32'(st(0, 0, 0, 1, 0)));
    paso();
    paso();
    Reset = 1'b1;

    // basic open / close
    veh = 1;
    paso();
    chequear("t1_espera", 32'(sa), 32'(st(0, 0, 0, 1, 0)));
    pv = 1; pin = 8'h2A;
    paso();
    pv = 0;
    chequear("t1_abre", 32'(sa), 32'(st(0, 0, 1, 0, 0)));
    term = 1; veh = 0;
    paso();
    term = 0;
    chequear("t1_cierra", 32'(sa), 32'(st(0, 0, 0, 1, 0)));

    // three wrong PINs then the right one
    veh = 1;
    paso();
    for (int i = 0; i < 3; i++) begin
      pv = 1;
      pin = (i == 0) ? 8'h00 : (i == 1) ? 8'h11 : 8'h22;
      paso();
      pv = 0;
      chequear($sformatf("t2_mal%0d", i), 32'(sa), 32'(st(0, i == 2, 0, 1, 4'(i + 1))));
    end
    pv = 1; pin = 8'h2A;
    paso();
    pv = 0;
    chequear("t2_ok", 32'(sa), 32'(st(0, 0, 1, 0, 0)));

    // tailgating lockout
    term = 1;
    paso();
    term = 0;
    chequear("t3_bloqueo", 32'(sa), 32'(st(1, 1, 0, 1, 0)));
    pv = 1; pin = 8'h55;
    paso();
    pv = 0;
    chequear("t3_mal_ignorado", 32'(sa), 32'(st(1, 1, 0, 1, 0)));
    pv = 1; pin = 8'h2A; veh = 0;
    paso();
    pv = 0;
    chequear("t3_libera", 32'(sa), 32'(st(0, 0, 0, 1, 0)));

    // auto-close after T_OPEN cycles
    veh = 1;
    paso();
    pv = 1; pin = 8'h2A;
    paso();
    pv = 0; veh = 0;
    n = 0;
    while (abi && n < 40) begin
      n++;
      paso();
    end
    chequear("t4_ciclos_abierto", 32'(n), 32'd16);
    chequear("t4_cerrado_17", 32'(sa), 32'(st(0, 0, 0, 1, 0)));

    // Termino on the expiry cycle
    veh = 1;
    paso();
    pv = 1; pin = 8'h2A;
    paso();
    pv = 0; veh = 0;
    repeat (15) paso();
    chequear("t4b_ultimo_ciclo", 32'(abi), 32'd1);
    term = 1;
    paso();
    term = 0;
    chequear("t4b_termino", 32'(sa), 32'(st(0, 0, 0, 1, 0)));

    // count persists across a back-out
    veh = 1;
    paso();
    pv = 1; pin = 8'h01;
    paso();
    pin = 8'h02;
    paso();
    pv = 0;
    chequear("t5_dos", 32'(sa), 32'(st(0, 0, 0, 1, 2)));
    veh = 0;
    paso();
    chequear("t5_retira", 32'(sa), 32'(st(0, 0, 0, 1, 2)));
    veh = 1;
    paso();
    pv = 1; pin = 8'h03;
    paso();
    pv = 0;
    chequear("t5_tres", 32'(sa), 32'(st(0, 1, 0, 1, 3)));
    // wrong PIN with vehicle drop: saturate and go idle
    pv = 1; pin = 8'h04; veh = 0;
    paso();
    pv = 0;
    chequear("t5_saturado", 32'(sa), 32'(st(0, 1, 0, 1, 3)));
    veh = 1;
    paso();
    pv = 1; pin = 8'h2A;
    paso();
    pv = 0;
    chequear("t5_ok", 32'(sa), 32'(st(0, 0, 1, 0, 0)));
    term = 1;
    paso();
    term = 0; veh = 0;
    chequear("t6_bloqueo", 32'(sa), 32'(st(1, 1, 0, 1, 0)));

    // asynchronous reset from BLOQUEO
    #3 Reset = 1'b0;
    #1;
    chequear("t6_reset_async", 32'(sa), 32'(st(0, 0, 0, 1, 0)));
    @(posedge Clk);
    #1 Reset = 1'b1;
    chequear("t6_reset_sostenido", 32'(sa), 32'(st(0, 0, 0, 1, 0)));
    // strobe in IDLE is ignored
    pv = 1; pin = 8'h00;
    paso();
    pv = 0;
    chequear("t6_pin_idle", 32'(sa), 32'(st(0, 0, 0, 1, 0)));
    veh = 1;
    paso();
    pv = 1; pin = 8'h2A;
    paso();
    pv = 0;
    chequear("t6_tras_reset", 32'(sa), 32'(st(0, 0, 1, 0, 0)));
    term = 1; veh = 0;
    paso();
    term = 0;

    // second configuration
    b_veh = 1;
    paso();
    for (int i = 0; i < 5; i++) begin
      b_pv = 1;
      b_pin = 12'(i * 3 + 1);
      paso();
      b_pv = 0;
      chequear($sformatf("b_mal%0d", i), 32'(sb), 32'(st(0, i == 4, 0, 1, 4'(i + 1))));
    end
    b_pv = 1; b_pin = 12'h777;
    paso();
    b_pv = 0;
    chequear("b_saturado", 32'(sb), 32'(st(0, 1, 0, 1, 5)));
    b_pv = 1; b_pin = 12'hA5C; b_veh = 0;
    paso();
    b_pv = 0;
    chequear("b_ok", 32'(sb), 32'(st(0, 0, 1, 0, 0)));
    n = 0;
    while (b_abi && n < 40) begin
      n++;
      paso();
    end
    chequear("b_ciclos_abierto", 32'(n), 32'd4);
    chequear("b_cerrado", 32'(sb), 32'(st(0, 0, 0, 1, 0)));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
